// File: rtl/au_selector_sequencer.sv
// Drives the three-wire project-selection bus: reset the selector chain, issue
// N increment pulses, then latch enable so exactly project N is active.
module au_selector_sequencer #(
    parameter int unsigned MAX_ADDR     = 31,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned PULSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              req_off,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              sel_rst_n,
    output logic              sel_inc,
    output logic              sel_ena,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              active_valid,
    output logic [ADDR_W-1:0] active_addr
);

    localparam int unsigned PH_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PULSE_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RST_LO, S_RST_HI, S_INC_HI, S_INC_LO,
        S_ENA_SETUP, S_ENA_HI, S_ENA_LO, S_DONE
    } state_t;

    state_t            state, state_d;
    logic [PH_W-1:0]   phase, phase_d;
    logic [ADDR_W-1:0] rem, rem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              off_q, off_d;
    logic              err_d, av_d;
    logic [ADDR_W-1:0] aa_d;
    logic              phase_end;

    assign phase_end = (phase == PH_LAST);

    always_comb begin
        state_d = state;
        phase_d = phase_end ? '0 : phase + PH_W'(1);
        rem_d   = rem;
        addr_d  = addr_q;
        off_d   = off_q;
        err_d   = 1'b0;
        av_d    = active_valid;
        aa_d    = active_addr;
        case (state)
            S_IDLE: begin
                phase_d = '0;
                if (req) begin
                    if (!req_off && (32'(req_addr) > MAX_ADDR)) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = req_addr;
                        off_d   = req_off;
                        rem_d   = req_addr;
                        av_d    = 1'b0;
                        state_d = S_RST_LO;
                    end
                end
            end
            S_RST_LO: if (phase_end) state_d = S_RST_HI;
            S_RST_HI: begin
                if (phase_end) begin
                    if (off_q)           state_d = S_DONE;
                    else if (rem != '0)  state_d = S_INC_HI;
                    else                 state_d = S_ENA_SETUP;
                end
            end
            S_INC_HI: if (phase_end) state_d = S_INC_LO;
            S_INC_LO: begin
                // rem is at least 1 here, so the decrement never wraps
                if (phase_end) begin
                    rem_d   = rem - ADDR_W'(1);
                    state_d = (rem != ADDR_W'(1)) ? S_INC_HI : S_ENA_SETUP;
                end
            end
            S_ENA_SETUP: if (phase_end) state_d = S_ENA_HI;
            S_ENA_HI:    if (phase_end) state_d = S_ENA_LO;
            S_ENA_LO:    if (phase_end) state_d = S_DONE;
            S_DONE: begin
                phase_d = '0;
                state_d = S_IDLE;
                av_d    = !off_q;
                aa_d    = off_q ? '0 : addr_q;
            end
            default: begin
                phase_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they are registered
    // yet aligned with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            phase        <= '0;
            rem          <= '0;
            addr_q       <= '0;
            off_q        <= 1'b0;
            sel_rst_n    <= 1'b0;
            sel_inc      <= 1'b0;
            sel_ena      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            active_valid <= 1'b0;
            active_addr  <= '0;
        end else begin
            state        <= state_d;
            phase        <= phase_d;
            rem          <= rem_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            sel_rst_n    <= (state_d != S_RST_LO);
            sel_inc      <= (state_d == S_INC_HI) || (state_d == S_ENA_HI);
            sel_ena      <= (state_d == S_ENA_SETUP) || (state_d == S_ENA_HI) ||
                            (state_d == S_ENA_LO);
            busy         <= (state_d != S_IDLE);
            done         <= (state_d == S_DONE);
            err          <= err_d;
            active_valid <= av_d;
            active_addr  <= aa_d;
        end
    end

endmodule

// File: tb/tb_au_selector_sequencer.sv
// Bench for au_selector_sequencer: two instances (P=2 with 6-bit address, P=1 with
// 5-bit address) checked against a selector-chain model and sequence-length formulas.
module tb_au_selector_sequencer;

    localparam int MAXA = 31;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req[2];
    logic       req_off[2];
    logic [5:0] req_addr[2];
    logic       sel_rst_n_w[2], sel_inc_w[2], sel_ena_w[2];
    logic       busy_w[2], done_w[2], err_w[2], av_w[2];
    logic [5:0] aa0;
    logic [4:0] aa1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    au_selector_sequencer #(.MAX_ADDR(31), .ADDR_W(6), .PULSE_CYCLES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .req_off(req_off[0]),
        .req_addr(req_addr[0]), .sel_rst_n(sel_rst_n_w[0]), .sel_inc(sel_inc_w[0]),
        .sel_ena(sel_ena_w[0]), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]),
        .active_valid(av_w[0]), .active_addr(aa0)
    );

    au_selector_sequencer #(.MAX_ADDR(31), .ADDR_W(5), .PULSE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .req_off(req_off[1]),
        .req_addr(req_addr[1][4:0]), .sel_rst_n(sel_rst_n_w[1]), .sel_inc(sel_inc_w[1]),
        .sel_ena(sel_ena_w[1]), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]),
        .active_valid(av_w[1]), .active_addr(aa1)
    );

    // Bus monitor and selector-chain model: each chain instance counts inc
    // edges while enable is low; an inc edge with enable high enables the
    // instance whose count matches its project number.
    int          busy_c[2]   = '{0, 0};
    int          done_c[2]   = '{0, 0};
    int          err_c[2]    = '{0, 0};
    int          cnt_edge[2] = '{0, 0};
    int          ena_edge[2] = '{0, 0};
    int          rstlo_c[2]  = '{0, 0};
    int          viol_c[2]   = '{0, 0};
    int          chain_cnt[2] = '{0, 0};
    logic [31:0] en_vec[2]   = '{32'd0, 32'd0};
    logic        inc_prev[2] = '{1'b0, 1'b0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (busy_w[d]) busy_c[d]++;
            if (done_w[d]) done_c[d]++;
            if (err_w[d]) err_c[d]++;
            if (!sel_rst_n_w[d] && rst_n) rstlo_c[d]++;
            if (sel_inc_w[d] && !sel_rst_n_w[d]) viol_c[d]++;
            if (done_w[d] && err_w[d]) viol_c[d]++;
            if (!sel_rst_n_w[d]) begin
                chain_cnt[d] = 0;
                en_vec[d]    = '0;
            end else if (sel_inc_w[d] && !inc_prev[d]) begin
                if (sel_ena_w[d]) begin
                    ena_edge[d]++;
                    en_vec[d] = (chain_cnt[d] < 32) ? (32'd1 << chain_cnt[d]) : 32'd0;
                end else begin
                    cnt_edge[d]++;
                    chain_cnt[d]++;
                end
            end
            inc_prev[d] = sel_inc_w[d];
        end
    end

    logic       exp_av[2] = '{1'b0, 1'b0};
    logic [5:0] exp_aa[2] = '{6'd0, 6'd0};

    function automatic logic [5:0] get_aa(input int d);
        return (d == 0) ? aa0 : {1'b0, aa1};
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input int d, input logic rst_released);
        chk($sformatf("rst%0d_sel_rst_n", d), 32'(sel_rst_n_w[d]), 32'(rst_released));
        chk($sformatf("rst%0d_sel_inc", d), 32'(sel_inc_w[d]), 0);
        chk($sformatf("rst%0d_sel_ena", d), 32'(sel_ena_w[d]), 0);
        chk($sformatf("rst%0d_busy", d), 32'(busy_w[d]), 0);
        chk($sformatf("rst%0d_done", d), 32'(done_w[d]), 0);
        chk($sformatf("rst%0d_err", d), 32'(err_w[d]), 0);
        chk($sformatf("rst%0d_av", d), 32'(av_w[d]), 0);
        chk($sformatf("rst%0d_aa", d), 32'(get_aa(d)), 0);
    endtask

    // One request on instance d; poke=1 fires a stray request while busy.
    task automatic run_req(input int d, input int addr, input logic off, input logic poke);
        int   p, b0, dn0, e0, ce0, ee0, rl0, v0, n;
        logic reject;
        p      = (d == 0) ? 2 : 1;
        reject = !off && (addr > MAXA);
        b0 = busy_c[d]; dn0 = done_c[d]; e0 = err_c[d]; ce0 = cnt_edge[d];
        ee0 = ena_edge[d]; rl0 = rstlo_c[d]; v0 = viol_c[d];
        req[d] = 1'b1; req_off[d] = off; req_addr[d] = 6'(addr);
        tick();
        req[d] = 1'b0;
        if (reject) begin
            tick(); tick(); tick();
            chk("rej_err_cycles", 32'(err_c[d] - e0), 1);
            chk("rej_busy", 32'(busy_c[d] - b0), 0);
            chk("rej_rst_lo", 32'(rstlo_c[d] - rl0), 0);
            chk("rej_inc_edges", 32'(cnt_edge[d] - ce0 + ena_edge[d] - ee0), 0);
        end else begin
            if (poke) begin
                tick();
                req[d] = 1'b1; req_off[d] = 1'b0; req_addr[d] = 6'd9;
                tick();
                req[d] = 1'b0;
            end
            n = 0;
            while (done_w[d] !== 1'b1 && n < 400) begin
                tick();
                n++;
            end
            chk("done_timeout", 32'(n < 400), 1);
            tick();
            exp_av[d] = !off;
            exp_aa[d] = off ? 6'd0 : 6'(addr);
            chk($sformatf("busy_len_a%0d_off%0d", addr, off), 32'(busy_c[d] - b0),
                off ? 32'(2 * p + 1) : 32'(p * (5 + 2 * addr) + 1));
            chk("done_pulses", 32'(done_c[d] - dn0), 1);
            chk("err_pulses", 32'(err_c[d] - e0), 0);
            chk("count_pulses", 32'(cnt_edge[d] - ce0), off ? 0 : 32'(addr));
            chk("enable_pulses", 32'(ena_edge[d] - ee0), off ? 0 : 1);
            chk("rst_lo_cycles", 32'(rstlo_c[d] - rl0), 32'(p));
            chk("chain_enables", en_vec[d], off ? 32'd0 : (32'd1 << addr));
        end
        chk("bus_violations", 32'(viol_c[d] - v0), 0);
        chk("active_valid", 32'(av_w[d]), 32'(exp_av[d]));
        chk("active_addr", 32'(get_aa(d)), 32'(exp_aa[d]));
    endtask

    initial begin
        int n, a;
        logic o;
        for (int d = 0; d < 2; d++) begin
            req[d] = 1'b0; req_off[d] = 1'b0; req_addr[d] = '0;
        end

        rst_n = 1'b0;
        tick(); tick(); tick();
        for (int d = 0; d < 2; d++) chk_reset_outputs(d, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("rel_sel_rst_n_still_low", 32'(sel_rst_n_w[0]), 0);
        tick();
        for (int d = 0; d < 2; d++) chk_reset_outputs(d, 1'b1);

        run_req(0, 3, 1'b0, 1'b1);
        run_req(1, 0, 1'b0, 1'b0);
        run_req(0, 31, 1'b0, 1'b0);
        run_req(1, 31, 1'b0, 1'b0);
        run_req(0, 5, 1'b0, 1'b0);
        run_req(0, 0, 1'b1, 1'b0);
        run_req(0, 12, 1'b0, 1'b0);
        run_req(0, 40, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, 45));
            o = ($urandom_range(0, 3) == 0);
            run_req(0, a, o, 1'(i % 3 == 0));
            a = int'($urandom_range(0, 31));
            o = ($urandom_range(0, 3) == 0);
            run_req(1, a, o, 1'b0);
        end

        req[0] = 1'b1; req_off[0] = 1'b0; req_addr[0] = 6'd20;
        tick();
        req[0] = 1'b0;
        n = 0;
        while (sel_inc_w[0] !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("inc_hi_timeout", 32'(n < 100), 1);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs(0, 1'b0);
        chk("abort_chain_enables", en_vec[0], 0);
        exp_av[0] = 1'b0; exp_aa[0] = '0;
        exp_av[1] = 1'b0; exp_aa[1] = '0;
        tick();
        rst_n = 1'b1;
        tick();
        run_req(0, 6, 1'b0, 1'b0);
        run_req(1, 17, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
